// File: rtl/dma_sram_rd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dma_sram_rd_pkg
// Purpose  : Shared definitions for the DMA SRAM read path.
//            - Bit positions of the 2-bit stream info field (first/last),
//              identical to the address generator's encoding.
//            - Default address/data widths.
//            - Ceiling-log2 helper for FIFO pointer sizing.
// Revision : 1.0  initial release
// ============================================================================
package dma_sram_rd_pkg;

  localparam int c_flag_first = 0;
  localparam int c_flag_last  = 1;
  localparam int c_flag_w     = 2;

  localparam int c_def_aw = 14;
  localparam int c_def_dw = 32;

  // Smallest r with 2**r >= value; used on constants only.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dma_sram_rd_fifo.sv
`default_nettype none
// ============================================================================
// Module   : dma_sram_rd_fifo
// Purpose  : Small synchronous FIFO holding data words plus stream flags.
//            Push and pop may occur in the same cycle. Pointers carry one
//            extra wrap bit, so count = wr_ptr - rd_ptr covers 0..DEPTH
//            (full <=> wrap bits differ and index bits match).
// Ports    : clk, rst_n      clock / async active-low reset
//            push, push_data write one entry
//            pop             discard the head entry (ignored when empty)
//            head_data       current head entry (undefined when count==0)
//            count           number of stored entries
// Revision : 1.0  initial release
// ============================================================================
module dma_sram_rd_fifo
  import dma_sram_rd_pkg::*;
#(
  parameter int W     = 34,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic [W-1:0]            push_data,
  input  logic                    pop,
  output logic [W-1:0]            head_data,
  output logic [clog2(DEPTH):0]   count
);

  localparam int c_iw = clog2(DEPTH);
  localparam int c_pw = c_iw + 1;

  logic [W-1:0]    r_mem [DEPTH];
  logic [c_pw-1:0] r_wr_ptr;
  logic [c_pw-1:0] r_rd_ptr;
  logic            w_pop;

  assign count     = r_wr_ptr - r_rd_ptr;
  assign w_pop     = pop & (count != '0);
  assign head_data = r_mem[r_rd_ptr[c_iw-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (push)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: entries are only visible through count.
  always_ff @(posedge clk) begin
    if (push) r_mem[r_wr_ptr[c_iw-1:0]] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/dma_sram_rd.sv
`default_nettype none
// ============================================================================
// Module   : dma_sram_rd
// Purpose  : Turns the DMA address stream into a data stream by reading a
//            single-port SRAM with fixed read latency. A credit scheme
//            reserves a buffer slot for every read before it is issued, so
//            downstream backpressure can never overflow the buffer.
// Ports    : clk, rst_n                      clock / async active-low reset
//            a_addr/a_first/a_last/a_valid/a_ready   address stream in
//            mem_ce/mem_addr/mem_rdata       SRAM read port
//            m_data/m_first/m_last/m_valid/m_ready   data stream out
//            busy                            frame in progress
// Revision : 1.0  initial release
// ============================================================================
module dma_sram_rd
  import dma_sram_rd_pkg::*;
#(
  parameter int AW     = c_def_aw,
  parameter int DW     = c_def_dw,
  parameter int RD_LAT = 1,
  parameter int DEPTH  = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] a_addr,
  input  logic          a_first,
  input  logic          a_last,
  input  logic          a_valid,
  output logic          a_ready,
  output logic          mem_ce,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] m_data,
  output logic          m_first,
  output logic          m_last,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          busy
);

  localparam int            c_pw    = clog2(DEPTH) + 1;
  localparam int            c_fw    = DW + c_flag_w;
  localparam logic [c_pw:0] c_depth = (c_pw + 1)'(DEPTH);

  // Stage k holds the read issued k cycles ago; stage 0 is the SRAM enable
  // itself and stage RD_LAT lines up with mem_rdata.
  logic [RD_LAT:0]     r_stg_v;
  logic [RD_LAT:0]     r_stg_f;
  logic [RD_LAT:0]     r_stg_l;
  logic [AW-1:0]       r_mem_addr;
  logic [c_pw-1:0]     r_inflight;
  logic                r_ready_en;
  logic                r_busy;

  logic [c_pw-1:0]     w_count;
  logic [c_pw:0]       w_credits;
  logic                w_accept;
  logic                w_land;
  logic                w_pop;
  logic [c_flag_w-1:0] w_land_flags;
  logic [c_fw-1:0]     w_head;

  // Credits depend on registered state only, never on m_ready.
  assign w_credits = c_depth - {1'b0, w_count} - {1'b0, r_inflight};
  assign a_ready   = r_ready_en & (w_credits != '0);
  assign w_accept  = a_valid & a_ready;
  assign w_land    = r_stg_v[RD_LAT];
  assign m_valid   = (w_count != '0);
  assign w_pop     = m_valid & m_ready;

  assign mem_ce    = r_stg_v[0];
  assign mem_addr  = r_mem_addr;
  assign busy      = r_busy;

  // Head fields are gated so the outputs read zero whenever nothing is valid.
  assign m_data    = m_valid ? w_head[c_fw-1:c_flag_w] : '0;
  assign m_first   = m_valid & w_head[c_flag_first];
  assign m_last    = m_valid & w_head[c_flag_last];

  always_comb begin
    w_land_flags               = '0;
    w_land_flags[c_flag_first] = r_stg_f[RD_LAT];
    w_land_flags[c_flag_last]  = r_stg_l[RD_LAT];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stg_v    <= '0;
      r_stg_f    <= '0;
      r_stg_l    <= '0;
      r_mem_addr <= '0;
      r_inflight <= '0;
      r_ready_en <= 1'b0;
    end else begin
      r_stg_v    <= {r_stg_v[RD_LAT-1:0], w_accept};
      r_stg_f    <= {r_stg_f[RD_LAT-1:0], w_accept & a_first};
      r_stg_l    <= {r_stg_l[RD_LAT-1:0], w_accept & a_last};
      // Landing moves a credit from in-flight to buffer: no net change.
      r_inflight <= r_inflight + c_pw'(w_accept) - c_pw'(w_land);
      r_ready_en <= 1'b1;
      if (w_accept) r_mem_addr <= a_addr;
    end
  end

  // A new frame starting on the cycle the previous one ends keeps busy set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
    end else if (w_accept & a_first) begin
      r_busy <= 1'b1;
    end else if (w_pop & m_last) begin
      r_busy <= 1'b0;
    end
  end

  dma_sram_rd_fifo #(
    .W     (c_fw),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_land),
    .push_data ({mem_rdata, w_land_flags}),
    .pop       (w_pop),
    .head_data (w_head),
    .count     (w_count)
  );

endmodule
`default_nettype wire
